// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
package booth_pkg;
  localparam int BOOTH_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M, then arithmetic
// right shift of {acc, Q, q_-1}.
module booth_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH+1:0] i_acc,
  input  logic [WIDTH:0]   i_q,
  input  logic             i_q1,
  input  logic [WIDTH:0]   i_m,
  output logic [WIDTH+1:0] o_acc,
  output logic [WIDTH:0]   o_q,
  output logic             o_q1
);
  logic [WIDTH+1:0] w_m_ext;
  logic [WIDTH+1:0] w_sum;

  assign w_m_ext = {i_m[WIDTH], i_m};

  always_comb begin
    w_sum = i_acc;
    case ({i_q[0], i_q1})
      2'b01:   w_sum = i_acc + w_m_ext;
      2'b10:   w_sum = i_acc - w_m_ext;
      default: w_sum = i_acc;
    endcase
  end

  assign o_acc = {w_sum[WIDTH+1], w_sum[WIDTH+1:1]};
  assign o_q   = {w_sum[0], i_q[WIDTH:1]};
  assign o_q1  = i_q[0];
endmodule

// File: rtl/booth_mult_seq.sv
// Sequential Booth multiplier: WIDTH+1 iterations on (WIDTH+1)-bit extended
// operands, so signed and unsigned share one datapath with fixed latency.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH
) (
  input  logic                 CLK100MHZ,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CW = $clog2(WIDTH + 2);

  state_t             r_state;
  logic [WIDTH+1:0]   r_acc;
  logic [WIDTH:0]     r_q;
  logic [WIDTH:0]     r_m;
  logic               r_q1;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH:0]     w_a_ext;
  logic [WIDTH:0]     w_b_ext;
  logic [WIDTH+1:0]   w_acc_nxt;
  logic [WIDTH:0]     w_q_nxt;
  logic               w_q1_nxt;

  // The extra top bit turns unsigned operands into non-negative signed ones.
  assign w_a_ext = {signed_mode & A[WIDTH-1], A};
  assign w_b_ext = {signed_mode & B[WIDTH-1], B};

  booth_step #(.WIDTH(WIDTH)) u_step (
    .i_acc (r_acc),
    .i_q   (r_q),
    .i_q1  (r_q1),
    .i_m   (r_m),
    .o_acc (w_acc_nxt),
    .o_q   (w_q_nxt),
    .o_q1  (w_q1_nxt)
  );

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_q       <= '0;
      r_m       <= '0;
      r_q1      <= 1'b0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_m       <= w_a_ext;
            r_q       <= w_b_ext;
            r_acc     <= '0;
            r_q1      <= 1'b0;
            r_cnt     <= CW'(WIDTH + 1);
            r_product <= '0;
            r_state   <= RUN;
          end
        end
        RUN: begin
          r_acc <= w_acc_nxt;
          r_q   <= w_q_nxt;
          r_q1  <= w_q1_nxt;
          r_cnt <= r_cnt - CW'(1);
          // Product fits in 2*WIDTH bits, so the upper acc bits are only sign.
          if (r_cnt == CW'(1)) begin
            r_product <= {w_acc_nxt[WIDTH-2:0], w_q_nxt};
            r_state   <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready   = (r_state == IDLE);
  assign busy    = (r_state == RUN);
  assign done    = (r_state == DONE);
  assign product = r_product;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench: arithmetic reference model plus directed vectors on
// 8-bit and 16-bit instances.
module tb_booth_mult_seq;
  logic clk = 1'b0;
  logic rst;
  logic st8, sm8, rdy8, bsy8, dn8;
  logic [7:0] a8, b8;
  logic [15:0] p8;
  logic st16, sm16, rdy16, bsy16, dn16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(8)) u8 (
    .CLK100MHZ(clk), .reset(rst), .start(st8), .signed_mode(sm8), .A(a8), .B(b8),
    .ready(rdy8), .busy(bsy8), .done(dn8), .product(p8));

  booth_mult_seq #(.WIDTH(16)) u16 (
    .CLK100MHZ(clk), .reset(rst), .start(st16), .signed_mode(sm16), .A(a16), .B(b16),
    .ready(rdy16), .busy(bsy16), .done(dn16), .product(p16));

  // Instance-indexed views for the model and compare process
  int          W[2] = '{8, 16};
  logic [31:0] ma[2], mb[2];
  logic        mst[2], msm[2], mrdy[2], mbsy[2], mdn[2];
  logic [63:0] mp[2];
  assign ma[0] = 32'(a8);   assign ma[1] = 32'(a16);
  assign mb[0] = 32'(b8);   assign mb[1] = 32'(b16);
  assign mst[0] = st8;      assign mst[1] = st16;
  assign msm[0] = sm8;      assign msm[1] = sm16;
  assign mrdy[0] = rdy8;    assign mrdy[1] = rdy16;
  assign mbsy[0] = bsy8;    assign mbsy[1] = bsy16;
  assign mdn[0] = dn8;      assign mdn[1] = dn16;
  assign mp[0] = 64'(p8);   assign mp[1] = 64'(p16);

  function automatic logic [63:0] calc(input logic [31:0] a, input logic [31:0] b,
                                       input bit sm, input int w);
    longint x, y, p, msk;
    msk = (longint'(1) << w) - 1;
    x = longint'(a) & msk;
    y = longint'(b) & msk;
    if (sm && x[w-1]) x = x - (longint'(1) << w);
    if (sm && y[w-1]) y = y - (longint'(1) << w);
    p = x * y;
    return 64'(p) & ((64'(1) << (2 * w)) - 64'(1));
  endfunction

  // Model: phase 0 = idle, 1..W+1 = running, W+2 = done cycle.
  int          ph[2];
  logic [63:0] ep[2], pend[2];
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        ph[i] <= 0;
        ep[i] <= '0;
      end else if (ph[i] == 0) begin
        if (mst[i]) begin
          ph[i]   <= 1;
          ep[i]   <= '0;
          pend[i] <= calc(ma[i], mb[i], msm[i], W[i]);
        end
      end else if (ph[i] == W[i] + 1) begin
        ph[i] <= W[i] + 2;
        ep[i] <= pend[i];
      end else if (ph[i] == W[i] + 2) begin
        ph[i] <= 0;
      end else begin
        ph[i] <= ph[i] + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("cyc_ready%0d", i), 64'(mrdy[i]), 64'(ph[i] == 0));
        chk($sformatf("cyc_busy%0d", i), 64'(mbsy[i]), 64'(ph[i] >= 1 && ph[i] <= W[i] + 1));
        chk($sformatf("cyc_done%0d", i), 64'(mdn[i]), 64'(ph[i] == W[i] + 2));
        chk($sformatf("cyc_product%0d", i), mp[i], ep[i]);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input int inst, input logic [31:0] a, input logic [31:0] b,
                       input bit sm, input bit st);
    if (inst == 0) begin
      a8 = a[7:0]; b8 = b[7:0]; sm8 = sm; st8 = st;
    end else begin
      a16 = a[15:0]; b16 = b[15:0]; sm16 = sm; st16 = st;
    end
  endtask

  task automatic run(input int inst, input logic [31:0] a, input logic [31:0] b,
                     input bit sm, input logic [63:0] exp, input string nm);
    int cyc;
    tick();
    drive(inst, a, b, sm, 1'b1);
    tick();
    drive(inst, a, b, sm, 1'b0);
    cyc = 1;
    while (!mdn[inst] && cyc < 60) begin
      tick();
      cyc++;
    end
    chk({nm, "_latency"}, 64'(cyc), 64'(W[inst] + 2));
    chk({nm, "_product"}, mp[inst], exp);
    chk({nm, "_model"}, ep[inst], exp);
  endtask

  initial begin
    int cyc, nd, dcyc, d1, d2;
    logic [63:0] dprod;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk_en = 1'b1;
    tick(); tick();
    chk("rst_ready", 64'(rdy8), 64'd1);
    chk("rst_busy", 64'(bsy8), 64'd0);
    chk("rst_done", 64'(dn8), 64'd0);
    chk("rst_product", 64'(p8), 64'd0);
    rst = 1'b0;

    run(0, 4, 7, 1, 64'd28, "s4x7");
    run(0, 32'h80, 32'h80, 1, 64'h4000, "s_min_min");
    run(0, 32'hFF, 32'h02, 1, 64'hFFFE, "s_m1x2");
    run(0, 32'hFF, 32'hFF, 0, 64'hFE01, "u_ffxff");
    run(0, 32'hFF, 32'h02, 0, 64'h01FE, "u_ffx2");
    run(0, 32'h7F, 32'h80, 1, 64'hC080, "s_maxxmin");

    // Second start during RUN must be ignored
    tick();
    drive(0, 3, 5, 1, 1);
    tick();
    drive(0, 3, 5, 1, 0);
    cyc = 1; nd = 0; dcyc = 0; dprod = '0;
    while (cyc < 16) begin
      tick();
      cyc++;
      if (cyc == 4) drive(0, 9, 9, 1, 1);
      if (cyc == 5) drive(0, 9, 9, 1, 0);
      if (dn8) begin nd++; dcyc = cyc; dprod = 64'(p8); end
    end
    chk("ignore_ndone", 64'(nd), 64'd1);
    chk("ignore_latency", 64'(dcyc), 64'd10);
    chk("ignore_product", dprod, 64'd15);

    // Reset in the middle of a run
    tick();
    drive(0, 7, 7, 1, 1);
    tick();
    drive(0, 7, 7, 1, 0);
    cyc = 1;
    while (cyc < 5) begin tick(); cyc++; end
    rst = 1'b1;
    #1;
    chk("midrst_ready", 64'(rdy8), 64'd1);
    chk("midrst_busy", 64'(bsy8), 64'd0);
    chk("midrst_done", 64'(dn8), 64'd0);
    chk("midrst_product", 64'(p8), 64'd0);
    tick();
    rst = 1'b0;
    nd = 0;
    repeat (15) begin tick(); if (dn8) nd++; end
    chk("midrst_nodone", 64'(nd), 64'd0);
    run(0, 2, 3, 1, 64'd6, "after_rst");

    // Start held high: back-to-back operations
    tick();
    drive(0, 5, 6, 0, 1);
    cyc = 0; d1 = 0; d2 = 0;
    while (cyc < 25) begin
      tick();
      cyc++;
      if (dn8) begin
        if (d1 == 0) d1 = cyc; else if (d2 == 0) d2 = cyc;
        chk("held_product", 64'(p8), 64'd30);
      end
    end
    chk("held_first", 64'(d1), 64'd10);
    chk("held_second", 64'(d2), 64'd21);
    drive(0, 5, 6, 0, 0);
    repeat (15) tick();

    run(1, 32'h8000, 32'h8000, 1, 64'h40000000, "w16_min_min");
    run(1, 32'hFFFF, 32'hFFFF, 0, 64'hFFFE0001, "w16_u_max");
    run(1, 32'hFFFF, 32'h0003, 1, 64'hFFFFFFFD, "w16_s_m1x3");

    tick();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout global_watchdog");
    $fatal(1, "watchdog expired");
  end
endmodule
